// File: rtl/heap_sort_ctrl.sv
// heap_sort_ctrl: sequences one heap sort job (init, round-robin load, flush, drain)
// and re-emits the sorted words with a job-level done/err.
// Optional build macro HEAP_CTRL_STATS_EN adds stat_cycles_o / stat_spurious_o counters.
module heap_sort_ctrl #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned KEY_WIDTH   = 4,
    parameter int unsigned NLEVELS     = 3,
    parameter int unsigned NREQ        = 2,
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned PUSH_GAP    = 1,
    parameter int unsigned DRAIN_TMO   = 64
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       start_i,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data_i,
    input  logic                       load_end_i,
    output logic [NREQ-1:0]            gnt_o,
    output logic [DATA_WIDTH-1:0]      heap_din_o,
    output logic                       heap_en_o,
    output logic                       heap_init_o,
    output logic                       heap_flush_o,
    input  logic [DATA_WIDTH-1:0]      heap_dout_i,
    input  logic                       heap_valid_i,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic                       out_valid_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [NLEVELS-1:0]         count_o
`ifdef HEAP_CTRL_STATS_EN
    ,
    output logic [15:0]                stat_cycles_o,
    output logic [7:0]                 stat_spurious_o
`endif
);

    localparam int unsigned CAP  = (1 << NLEVELS) - 1;
    localparam int unsigned RW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TMAX = (INIT_CYCLES > DRAIN_TMO) ? INIT_CYCLES : DRAIN_TMO;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned GW   = $clog2(PUSH_GAP + 1);

    // The key field is carried inside the word untouched; it only has to fit.
    if (KEY_WIDTH > DATA_WIDTH) begin : g_bad_key_width
        $error("heap_sort_ctrl: KEY_WIDTH exceeds DATA_WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_LOAD, S_FLUSH, S_DRAIN, S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [RW-1:0]           rr_q, rr_d;
    logic [NLEVELS-1:0]      count_q, count_d;
    logic [NLEVELS-1:0]      rem_q, rem_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic                    en_q, en_d;
    logic                    init_q, init_d;
    logic                    flush_q, flush_d;
    logic [DATA_WIDTH-1:0]   odata_q, odata_d;
    logic                    ovalid_q, ovalid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    win_found;
    logic [RW-1:0]           win_idx;
    logic [DATA_WIDTH-1:0]   win_word;
    logic                    slot_open;
    logic                    push;

    // Round-robin winner: first requester at/after the pointer, then wrap below it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_word  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_i[i] && (RW'(i) >= rr_q)) begin
                win_found = 1'b1;
                win_idx   = RW'(i);
                win_word  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_i[i]) begin
                win_found = 1'b1;
                win_idx   = RW'(i);
                win_word  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A push may be issued only after PUSH_GAP idle cycles since the last heap_en pulse.
    assign slot_open = !en_q && (gap_q >= GW'(PUSH_GAP - 1));
    assign push      = (state_q == S_LOAD) && slot_open && win_found;

    // Next-state and next-output computation for the job sequencer.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        count_d  = count_q;
        rem_d    = rem_q;
        tmr_d    = tmr_q;
        gap_d    = gap_q;
        gnt_d    = '0;
        din_d    = din_q;
        en_d     = 1'b0;
        init_d   = 1'b0;
        flush_d  = 1'b0;
        odata_d  = odata_q;
        ovalid_d = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    count_d = '0;
                    err_d   = 1'b0;
                    init_d  = 1'b1;
                    tmr_d   = '0;
                end
            end
            S_INIT: begin
                if (tmr_q == TW'(INIT_CYCLES)) begin
                    state_d = S_LOAD;
                    gap_d   = GW'(PUSH_GAP);
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_LOAD: begin
                if (en_q) begin
                    gap_d = '0;
                end else if (gap_q != GW'(PUSH_GAP)) begin
                    gap_d = gap_q + GW'(1);
                end
                if (push) begin
                    en_d          = 1'b1;
                    din_d         = win_word;
                    gnt_d[win_idx] = 1'b1;
                    rr_d          = (win_idx == RW'(NREQ - 1)) ? '0 : win_idx + RW'(1);
                    count_d       = count_q + NLEVELS'(1);
                end
                if ((push && (count_q == NLEVELS'(CAP - 1))) ||
                    (load_end_i && (push || (count_q != '0)))) begin
                    state_d = S_FLUSH;
                end else if (load_end_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                rem_d   = count_q;
                tmr_d   = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (heap_valid_i) begin
                    ovalid_d = 1'b1;
                    odata_d  = heap_dout_i;
                    rem_d    = rem_q - NLEVELS'(1);
                    tmr_d    = '0;
                    if (rem_q == NLEVELS'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else if (tmr_q == TW'(DRAIN_TMO - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered-output update; reset aborts any job silently.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            tmr_q    <= '0;
            gap_q    <= '0;
            gnt_q    <= '0;
            din_q    <= '0;
            en_q     <= 1'b0;
            init_q   <= 1'b0;
            flush_q  <= 1'b0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            tmr_q    <= tmr_d;
            gap_q    <= gap_d;
            gnt_q    <= gnt_d;
            din_q    <= din_d;
            en_q     <= en_d;
            init_q   <= init_d;
            flush_q  <= flush_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign heap_din_o   = din_q;
    assign heap_en_o    = en_q;
    assign heap_init_o  = init_q;
    assign heap_flush_o = flush_q;
    assign out_data_o   = odata_q;
    assign out_valid_o  = ovalid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign count_o      = count_q;

`ifdef HEAP_CTRL_STATS_EN
    logic [15:0] scyc_q;
    logic [7:0]  sspur_q;

    // Job cycle count and heap_valid-outside-drain count, both saturating.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            scyc_q  <= '0;
            sspur_q <= '0;
        end else if (start_i && (state_q == S_IDLE)) begin
            scyc_q  <= '0;
            sspur_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (scyc_q != 16'hFFFF)) begin
                scyc_q <= scyc_q + 16'd1;
            end
            if (heap_valid_i && (state_q != S_DRAIN) && (sspur_q != 8'hFF)) begin
                sspur_q <= sspur_q + 8'd1;
            end
        end
    end

    assign stat_cycles_o   = scyc_q;
    assign stat_spurious_o = sspur_q;
`endif

endmodule

// File: tb/tb_heap_sort_ctrl.sv
// Bench for heap_sort_ctrl: requester and heap models plus an output scoreboard.
`timescale 1ns/1ps
module tb_heap_sort_ctrl;

    localparam int unsigned DW      = 8;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned NLEVELS = 3;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic                 load_end = 1'b0;
    logic [DW-1:0]        heap_dout = '0;
    logic                 heap_valid = 1'b0;

    logic [NREQ-1:0]      gnt;
    logic [DW-1:0]        heap_din;
    logic                 heap_en, heap_init, heap_flush;
    logic [DW-1:0]        out_data;
    logic                 out_valid, busy, done, err;
    logic [NLEVELS-1:0]   count;
`ifdef HEAP_CTRL_STATS_EN
    logic [15:0]          stat_cycles;
    logic [7:0]           stat_spurious;
`endif

    heap_sort_ctrl u_dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .start_i      (start),
        .req_i        (req),
        .req_data_i   (req_data),
        .load_end_i   (load_end),
        .gnt_o        (gnt),
        .heap_din_o   (heap_din),
        .heap_en_o    (heap_en),
        .heap_init_o  (heap_init),
        .heap_flush_o (heap_flush),
        .heap_dout_i  (heap_dout),
        .heap_valid_i (heap_valid),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .count_o      (count)
`ifdef HEAP_CTRL_STATS_EN
        ,
        .stat_cycles_o   (stat_cycles),
        .stat_spurious_o (stat_spurious)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DW-1:0] rq0[$];
    logic [DW-1:0] rq1[$];
    logic [DW-1:0] hq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] stim_q[$];
    logic [DW-1:0] tmp_q[$];

    int rr_m = 0;
    bit draining = 1'b0, kill_valid = 1'b0, end_arm = 1'b0, end_clr = 1'b0;
    int n_gnt = 0, n_en = 0, n_flush = 0, n_done = 0, n_init = 0, n_out = 0;
    int last_en = -100, init_cyc = 0, first_gnt = -1, flush_cyc = 0, done_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Index at which v keeps q ordered by ascending key (stable for equal keys).
    function automatic int key_pos(input logic [DW-1:0] v, input logic [DW-1:0] q[$]);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i][3:0] > v[3:0]) return i;
        end
        return q.size();
    endfunction

    // Expected drain order for the words about to be offered.
    task automatic push_expected();
        tmp_q.delete();
        foreach (stim_q[i]) tmp_q.insert(key_pos(stim_q[i], tmp_q), stim_q[i]);
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
        stim_q.delete();
    endtask

    function automatic int exp_winner();
        int i;
        for (int k = 0; k < NREQ; k++) begin
            i = (rr_m + k) % NREQ;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor, heap model and requester drivers.
    always @(negedge clk) begin
        int w;
        if (rstn) begin
            if (out_valid) begin
                n_out++;
                if (exp_q.size() == 0) check_eq("out_extra", 32'(out_valid), 32'(0));
                else check_eq("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (heap_en) begin
                check_eq("en_gap", 32'(cyc - last_en >= 2), 32'(1));
                last_en = cyc;
                n_en++;
            end
            if (gnt != '0) begin
                w = exp_winner();
                check_eq("gnt", 32'(gnt), (w < 0) ? 32'(0) : 32'(1) << w);
                check_eq("gnt_en", 32'(heap_en), 32'(1));
                if (w == 0 && rq0.size() > 0) begin
                    check_eq("din0", 32'(heap_din), 32'(rq0[0]));
                    void'(rq0.pop_front());
                end else if (w == 1 && rq1.size() > 0) begin
                    check_eq("din1", 32'(heap_din), 32'(rq1[0]));
                    void'(rq1.pop_front());
                end
                if (w >= 0) rr_m = (w + 1) % NREQ;
                if (first_gnt < 0) first_gnt = cyc;
                n_gnt++;
            end
            if (heap_flush) begin n_flush++; flush_cyc = cyc; end
            if (heap_init) begin n_init++; init_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end

            if (heap_init) hq.delete();
            if (heap_en) hq.insert(key_pos(heap_din, hq), heap_din);
            if (heap_flush) begin
                draining   = 1'b1;
                heap_valid = 1'b0;
            end else if (draining && !kill_valid && hq.size() > 0) begin
                heap_valid = 1'b1;
                heap_dout  = hq.pop_front();
            end else begin
                heap_valid = 1'b0;
                if (hq.size() == 0) draining = 1'b0;
            end

            req[0] = (rq0.size() > 0);
            req[1] = (rq1.size() > 0);
            req_data[DW-1:0]    = (rq0.size() > 0) ? rq0[0] : '0;
            req_data[2*DW-1:DW] = (rq1.size() > 0) ? rq1[0] : '0;
            if (end_arm && rq0.size() == 0 && rq1.size() == 0) begin
                load_end = 1'b1;
                end_arm  = 1'b0;
                end_clr  = 1'b1;
            end else if (end_clr) begin
                load_end = 1'b0;
                end_clr  = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_job(input string tag, input int exp_cnt, input int exp_gnt,
                           input bit exp_err, input int exp_flush);
        bit got_done;
        got_done = 1'b0;
        n_gnt = 0; n_en = 0; n_flush = 0; n_done = 0; n_init = 0; first_gnt = -1;
        pulse_start();
        check_eq({tag, "_err_clr"}, 32'(err), 32'(0));
        check_eq({tag, "_busy"}, 32'(busy), 32'(1));
        for (int i = 0; i < 400 && !got_done; i++) begin
            @(posedge clk); #1;
            if (done) got_done = 1'b1;
        end
        check_eq({tag, "_done"}, 32'(got_done), 32'(1));
        check_eq({tag, "_count"}, 32'(count), 32'(exp_cnt));
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        @(posedge clk); #1;
        check_eq({tag, "_done_1cyc"}, 32'(done), 32'(0));
        check_eq({tag, "_idle"}, 32'(busy), 32'(0));
        check_eq({tag, "_ngnt"}, 32'(n_gnt), 32'(exp_gnt));
        check_eq({tag, "_nen"}, 32'(n_en), 32'(exp_gnt));
        check_eq({tag, "_nflush"}, 32'(n_flush), 32'(exp_flush));
        check_eq({tag, "_ninit"}, 32'(n_init), 32'(1));
        check_eq({tag, "_ndone"}, 32'(n_done), 32'(1));
        check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt"}, 32'(gnt), 32'(0));
        check_eq({tag, "_din"}, 32'(heap_din), 32'(0));
        check_eq({tag, "_ctl"}, 32'({heap_en, heap_init, heap_flush}), 32'(0));
        check_eq({tag, "_out"}, 32'({out_data, out_valid}), 32'(0));
        check_eq({tag, "_stat"}, 32'({busy, done, err}), 32'(0));
        check_eq({tag, "_count"}, 32'(count), 32'(0));
    endtask

    initial begin
        int base;
        #12;
        check_all_zero("rst");
        @(negedge clk); #2 rstn = 1'b1;

        // 1: single requester, four words, explicit end
        rq0 = '{8'hA5, 8'hB3, 8'hC9, 8'hD1};
        stim_q = '{8'hA5, 8'hB3, 8'hC9, 8'hD1};
        push_expected();
        end_arm = 1'b1;
        run_job("t1", 4, 4, 1'b0, 1);
        check_eq("t1_init_wait", 32'(first_gnt - init_cyc), 32'(6));

        // 2: both requesters held, grants alternate
        rq0 = '{8'h1C, 8'h27, 8'h3A};
        rq1 = '{8'h48, 8'h52, 8'h6F};
        stim_q = '{8'h1C, 8'h27, 8'h3A, 8'h48, 8'h52, 8'h6F};
        push_expected();
        end_arm = 1'b1;
        run_job("t2", 6, 6, 1'b0, 1);

        // 3: capacity reached without load_end; eighth word stays pending
        rq0 = '{8'h07, 8'h12, 8'h2E, 8'h34, 8'h4B, 8'h50, 8'h69, 8'h75};
        stim_q = '{8'h07, 8'h12, 8'h2E, 8'h34, 8'h4B, 8'h50, 8'h69};
        push_expected();
        run_job("t3", 7, 7, 1'b0, 1);
        check_eq("t3_left", 32'(rq0.size()), 32'(1));
        rq0.delete();
        repeat (2) @(posedge clk);

        // 4: load_end in the first LOAD cycle, nothing pushed
        n_en = 0; n_flush = 0; n_done = 0;
        pulse_start();
        repeat (5) @(posedge clk);
        #1 load_end = 1'b1;
        @(posedge clk); #1 load_end = 1'b0;
        check_eq("t4_done", 32'(done), 32'(1));
        check_eq("t4_count", 32'(count), 32'(0));
        @(posedge clk); #1;
        check_eq("t4_idle", 32'({busy, done}), 32'(0));
        check_eq("t4_nen", 32'(n_en), 32'(0));
        check_eq("t4_nflush", 32'(n_flush), 32'(0));
        check_eq("t4_ndone", 32'(n_done), 32'(1));

        // 5: heap never answers in DRAIN -> timeout with err
        rq1 = '{8'h8D, 8'h96};
        end_arm = 1'b1;
        kill_valid = 1'b1;
        run_job("t5", 2, 2, 1'b1, 1);
        check_eq("t5_tmo_len", 32'(done_cyc - flush_cyc), 32'(64));
        base = n_out;
        kill_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("t5_spurious_out", 32'(n_out - base), 32'(0));
        check_eq("t5_err_held", 32'(err), 32'(1));
        rq0 = '{8'h13};
        stim_q = '{8'h13};
        push_expected();
        end_arm = 1'b1;
        run_job("t5b", 1, 1, 1'b0, 1);

        // 6: reset mid-DRAIN, then a clean job
        rq0 = '{8'h0A, 8'h13, 8'h2C, 8'h31, 8'h45};
        stim_q = '{8'h0A, 8'h13, 8'h2C, 8'h31, 8'h45};
        push_expected();
        end_arm = 1'b1;
        base = n_out;
        pulse_start();
        for (int i = 0; i < 200 && (n_out - base) < 2; i++) @(posedge clk);
        check_eq("t6_reached_drain", 32'(n_out - base >= 2), 32'(1));
        #3 rstn = 1'b0;
        #1 check_all_zero("t6_rst");
        exp_q.delete(); hq.delete(); rq0.delete(); rq1.delete();
        draining = 1'b0; end_arm = 1'b0; end_clr = 1'b0;
        load_end = 1'b0; heap_valid = 1'b0; req = '0; rr_m = 0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        rq0 = '{8'h42};
        rq1 = '{8'h37};
        stim_q = '{8'h42, 8'h37};
        push_expected();
        end_arm = 1'b1;
        run_job("t6b", 2, 2, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
